iiitb_seq_gen: RTL and testbench

IIITB_SEQ_GEN -- requirements
Module: iiitb_seq_gen

---
 rtl/iiitb_seq_gen_pkg.sv | 15 +
 rtl/iiitb_seq_gen_piso.sv | 31 +++
 rtl/iiitb_seq_gen.sv | 149 ++++++++++++++
 tb/tb_iiitb_seq_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/iiitb_seq_gen_pkg.sv
// Shared definitions for the iiitb_seq_gen serial pattern generator:
// FSM state encoding, the built-in default pattern and the repetition-count width.
package iiitb_seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         REPS_W        = 4;
    localparam logic [3:0] DEFAULT_PAT_C = 4'b1001;

endpackage

// File: rtl/iiitb_seq_gen_piso.sv
// Parallel-in serial-out shift register: loads a WIDTH-bit word and presents it MSB first.
// Load has priority over shift; zeros are shifted in at the LSB.
module iiitb_seq_gen_piso #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] data_r;

    // Shift register with synchronous clear, parallel load and left shift
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= '0;
        end else if (load) begin
            data_r <= din;
        end else if (shift) begin
            data_r <= {data_r[WIDTH-2:0], 1'b0};
        end else begin
            data_r <= data_r;
        end
    end

    assign msb = data_r[WIDTH-1];

endmodule

// File: rtl/iiitb_seq_gen.sv
// Burst serial pattern generator: sends (reps+1) MSB-first copies of a pattern,
// optionally separated by one idle cycle, then pulses done. Moore outputs only.
module iiitb_seq_gen
    import iiitb_seq_gen_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] DEFAULT_PAT = WIDTH'(DEFAULT_PAT_C)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              use_default,
    input  logic [WIDTH-1:0]  pattern,
    input  logic [REPS_W-1:0] reps,
    input  logic              gap_en,
    input  logic              abort,
    output logic              ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              done
);

    localparam int               BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    state_t            state_r;
    state_t            state_next_s;
    logic [WIDTH-1:0]  pat_r;
    logic [REPS_W-1:0] reps_r;
    logic              gap_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [BIT_W-1:0]  bit_cnt_next_s;
    logic [REPS_W-1:0] copy_cnt_r;
    logic [REPS_W-1:0] copy_cnt_next_s;
    logic              capture_s;
    logic              load_s;
    logic              shift_s;
    logic [WIDTH-1:0]  sel_pat_s;
    logic [WIDTH-1:0]  load_val_s;
    logic              msb_s;

    assign sel_pat_s = use_default ? DEFAULT_PAT : pattern;

    // Next-state, counter and shift-register control decode
    always_comb begin
        state_next_s    = state_r;
        bit_cnt_next_s  = bit_cnt_r;
        copy_cnt_next_s = copy_cnt_r;
        capture_s       = 1'b0;
        load_s          = 1'b0;
        shift_s         = 1'b0;
        load_val_s      = pat_r;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    state_next_s    = SHIFT;
                    capture_s       = 1'b1;
                    load_s          = 1'b1;
                    load_val_s      = sel_pat_s;
                    bit_cnt_next_s  = '0;
                    copy_cnt_next_s = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next_s    = IDLE;
                    bit_cnt_next_s  = '0;
                    copy_cnt_next_s = '0;
                end else if (bit_cnt_r == BIT_LAST) begin
                    bit_cnt_next_s = '0;
                    if (copy_cnt_r == reps_r) begin
                        state_next_s    = DONE;
                        copy_cnt_next_s = '0;
                    end else begin
                        // Reload now; during GAP the register holds while dout is masked
                        load_s          = 1'b1;
                        copy_cnt_next_s = copy_cnt_r + REPS_W'(1);
                        state_next_s    = gap_r ? GAP : SHIFT;
                    end
                end else begin
                    shift_s        = 1'b1;
                    bit_cnt_next_s = bit_cnt_r + BIT_W'(1);
                end
            end
            GAP: begin
                if (abort) begin
                    state_next_s    = IDLE;
                    bit_cnt_next_s  = '0;
                    copy_cnt_next_s = '0;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s    = IDLE;
                bit_cnt_next_s  = '0;
                copy_cnt_next_s = '0;
            end
        endcase
    end

    // State, progress counters and burst configuration captured at acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            bit_cnt_r  <= '0;
            copy_cnt_r <= '0;
            pat_r      <= '0;
            reps_r     <= '0;
            gap_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            copy_cnt_r <= copy_cnt_next_s;
            if (capture_s) begin
                pat_r  <= sel_pat_s;
                reps_r <= reps;
                gap_r  <= gap_en;
            end else begin
                pat_r  <= pat_r;
                reps_r <= reps_r;
                gap_r  <= gap_r;
            end
        end
    end

    iiitb_seq_gen_piso #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .shift (shift_s),
        .din   (load_val_s),
        .msb   (msb_s)
    );

    // Outputs depend only on registered state and the shift-register MSB
    assign ready      = (state_r == IDLE);
    assign dout_valid = (state_r == SHIFT);
    assign dout       = (state_r == SHIFT) & msb_s;
    assign done       = (state_r == DONE);

endmodule

// File: tb/tb_iiitb_seq_gen.sv
// Self-checking bench for iiitb_seq_gen: a queue-based burst model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_iiitb_seq_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       use_default;
    logic [3:0] pattern;
    logic [3:0] reps;
    logic       gap_en;
    logic       abort;
    logic       ready;
    logic       dout;
    logic       dout_valid;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    iiitb_seq_gen #(
        .WIDTH       (4),
        .DEFAULT_PAT (4'b1001)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .use_default (use_default),
        .pattern     (pattern),
        .reps        (reps),
        .gap_en      (gap_en),
        .abort       (abort),
        .ready       (ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .done        (done)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got 'h%0h, expected 'h%0h", name, $time, got, exp);
        end
    endtask

    // Model: queue of expected {ready,dout,dout_valid,done} for the current and future cycles
    logic [3:0] q[$];

    task automatic build_burst();
        logic [3:0] p;
        p = use_default ? 4'b1001 : pattern;
        for (int c = 0; c <= int'(reps); c++) begin
            if (c > 0 && gap_en) q.push_back(4'b0000);
            for (int b = 3; b >= 0; b--) q.push_back({1'b0, p[b], 1'b1, 1'b0});
        end
        q.push_back(4'b0001);
    endtask

    always @(posedge clk) begin
        if (reset) q.delete();
        else if (q.size() != 0) begin
            if (abort) q.delete();
            else void'(q.pop_front());
        end
        else if (start && !abort) build_burst();
    end

    always @(negedge clk) begin
        if (checking) begin
            check("model_cmp", {ready, dout, dout_valid, done},
                  (q.size() != 0) ? q[0] : 4'b1000);
        end
    end

    // Per-burst observation records
    logic [63:0] vbits;
    int          vcount, done_cnt, done_at, det_cnt, det_last, det_space;
    logic [3:0]  det_hist;
    logic        rdy [0:127];
    logic        vld [0:127];

    task automatic burst(input int n, input int hold, input int abort_at, input int restart_at);
        vbits = '0; vcount = 0; done_cnt = 0; done_at = 0;
        det_hist = 4'b0000; det_cnt = 0; det_last = 0; det_space = 0;
        start = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            rdy[c] = ready;
            vld[c] = dout_valid;
            if (dout_valid) begin
                vbits = {vbits[62:0], dout};
                vcount++;
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            det_hist = {det_hist[2:0], dout};
            if (det_hist == 4'b1001) begin
                det_cnt++;
                det_space = c - det_last;
                det_last  = c;
            end
            if (c == 1) pattern = ~pattern;
            start = (c < hold) || (c == restart_at);
            abort = (c == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; use_default = 1'b0;
        gap_en = 1'b0; pattern = 4'b0000; reps = 4'd0;
        repeat (2) @(negedge clk);
        check("reset_ready", ready, 1'b1);
        check("reset_valid", dout_valid, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_dout", dout, 1'b0);
        checking = 1'b1;

        // Default pattern, first cycle out of reset, back-to-back restart after DONE
        reset = 1'b0; use_default = 1'b1; pattern = 4'b0110; reps = 4'd0; gap_en = 1'b0;
        burst(12, 1, 0, 6);
        check("def_bits", vbits[7:0], 8'b10011001);
        check("def_vcount", vcount, 8);
        check("def_done_at", done_at, 5);
        check("def_ready6", rdy[6], 1'b1);
        check("b2b_valid7", vld[7], 1'b1);
        check("b2b_done_cnt", done_cnt, 2);

        // User pattern, two copies with a gap
        use_default = 1'b0; pattern = 4'b1011; reps = 4'd1; gap_en = 1'b1;
        burst(11, 1, 0, 0);
        check("gap_bits", vbits[7:0], 8'b10111011);
        check("gap_vcount", vcount, 8);
        check("gap_idle5", vld[5], 1'b0);
        check("gap_done_at", done_at, 10);

        // Three copies without gap into a 1001 detector
        use_default = 1'b1; reps = 4'd2; gap_en = 1'b0;
        burst(16, 1, 0, 0);
        check("loop_bits", vbits[11:0], 12'b100110011001);
        check("loop_det_cnt", det_cnt, 3);
        check("loop_det_space", det_space, 4);
        check("loop_done_at", done_at, 13);

        // Abort during copy 2, restart one cycle later
        use_default = 1'b1; reps = 4'd2; gap_en = 1'b0;
        burst(22, 1, 7, 8);
        check("abort_ready8", rdy[8], 1'b1);
        check("abort_valid8", vld[8], 1'b0);
        check("restart_valid9", vld[9], 1'b1);
        check("abort_vcount", vcount, 19);
        check("abort_done_cnt", done_cnt, 1);
        check("abort_done_at", done_at, 21);

        // Single copy with gap enabled: no gap cycle
        use_default = 1'b0; pattern = 4'b0110; reps = 4'd0; gap_en = 1'b1;
        burst(6, 1, 0, 0);
        check("one_bits", vbits[3:0], 4'b0110);
        check("one_vcount", vcount, 4);
        check("one_done_at", done_at, 5);

        // Sixteen copies with start held throughout the burst
        use_default = 1'b0; pattern = 4'b1100; reps = 4'd15; gap_en = 1'b0;
        burst(70, 65, 0, 0);
        check("max_vcount", vcount, 64);
        check("max_bits", vbits[15:0], 16'b1100110011001100);
        check("max_done_cnt", done_cnt, 1);
        check("max_done_at", done_at, 65);

        // Abort beats start in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        check("abort_start_ready", ready, 1'b1);
        check("abort_start_valid", dout_valid, 1'b0);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);

        // Reset mid-burst with start held high
        use_default = 1'b1; reps = 4'd3; gap_en = 1'b0; start = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", dout_valid, 1'b0);
        check("rst_mid_ready", ready, 1'b1);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_dout", dout, 1'b0);
        @(negedge clk);
        check("rst_hold_ready", ready, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rel_valid", dout_valid, 1'b1);
        check("rst_rel_dout", dout, 1'b1);
        start = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst_done_cnt", done_cnt, 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
